// File: rtl/hazard_unit_if.sv
// Hazard unit bundle: Decode/Execute status in, forward selects, stall/flush controls and counters out.
interface hazard_unit_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] ra1_d, ra2_d, wa_d;
  logic             reg_write_d, mem_to_reg_d, branch_taken_e;
  logic [1:0]       forwardAE, forwardBE;
  logic             stall_f, stall_d, flush_d, flush_e;
  logic [CNT_W-1:0] stall_count, flush_count;

  modport master (
    output ra1_d, ra2_d, wa_d, reg_write_d, mem_to_reg_d, branch_taken_e,
    input  forwardAE, forwardBE, stall_f, stall_d, flush_d, flush_e,
           stall_count, flush_count
  );

  modport slave (
    input  ra1_d, ra2_d, wa_d, reg_write_d, mem_to_reg_d, branch_taken_e,
    output forwardAE, forwardBE, stall_f, stall_d, flush_d, flush_e,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: shadow E/M/W tracking, operand forwarding, load-use stall,
// branch flush and saturating stall/flush event counters.
module hazard_fwd_sel #(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] m_wa,
  input  logic             m_hit,
  input  logic [REG_W-1:0] w_wa,
  input  logic             w_hit,
  output logic [1:0]       sel
);
  // Memory stage holds the younger result, so it beats writeback.
  always_comb begin
    sel = 2'b00;
    if (m_hit && m_wa == ra)      sel = 2'b10;
    else if (w_hit && w_wa == ra) sel = 2'b01;
  end
endmodule

module hazard_unit #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hif
);
  localparam int STAGES = 2;  // vld_pipe[0]=E, [1]=M, [2]=W

  typedef struct packed {
    logic [REG_W-1:0] ra1;
    logic [REG_W-1:0] ra2;
    logic [REG_W-1:0] wa;
    logic             reg_write;
    logic             mem_to_reg;
  } e_ent_t;

  typedef struct packed {
    logic [REG_W-1:0] wa;
    logic             reg_write;
  } wb_ent_t;

  e_ent_t              e_q;
  wb_ent_t             m_q, w_q;
  logic [STAGES:0]     vld_pipe;
  logic [CNT_W-1:0]    stall_cnt, flush_cnt;
  logic                lu, br;
  logic [1:0][REG_W-1:0] e_ra;
  logic [1:0][1:0]     fwd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      e_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ~hif.flush_e};
      e_q      <= '{ra1: hif.ra1_d, ra2: hif.ra2_d, wa: hif.wa_d,
                    reg_write: hif.reg_write_d, mem_to_reg: hif.mem_to_reg_d};
      m_q      <= '{wa: e_q.wa, reg_write: e_q.reg_write};
      w_q      <= m_q;
    end
  end

  // Hazard controls are purely combinational; gating with rst keeps them quiet
  // during reset even while branch_taken_e is driven.
  assign lu = vld_pipe[0] && e_q.mem_to_reg &&
              (e_q.wa == hif.ra1_d || e_q.wa == hif.ra2_d);
  assign br = rst && hif.branch_taken_e;

  assign hif.stall_f = rst && lu && !br;
  assign hif.stall_d = rst && lu && !br;
  assign hif.flush_d = br;
  assign hif.flush_e = br || (rst && lu);

  assign e_ra = {e_q.ra2, e_q.ra1};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
      .ra    (e_ra[i]),
      .m_wa  (m_q.wa),
      .m_hit (vld_pipe[1] && m_q.reg_write),
      .w_wa  (w_q.wa),
      .w_hit (vld_pipe[2] && w_q.reg_write),
      .sel   (fwd[i])
    );
  end

  assign hif.forwardAE = fwd[0];
  assign hif.forwardBE = fwd[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hif.stall_d && stall_cnt != '1)        stall_cnt <= stall_cnt + CNT_W'(1);
      if (hif.branch_taken_e && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hif.stall_count = stall_cnt;
  assign hif.flush_count = flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Randomized + directed bench for hazard_unit against a queue-based reference of in-flight instructions.
module tb_hazard_unit;
  localparam int REG_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk, rst;
  hazard_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif();
  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hif(hif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ra1, ra2, wa;
    bit rw, ld, v;
  } ins_t;

  ins_t mq[$];          // [0]=Execute, [1]=Memory, [2]=Writeback
  int   m_stall, m_flush;
  ins_t cur;
  bit   cur_br, x_st, x_fe;
  int   n_tot, n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
    // Youngest in-flight writer of ra supplies the operand.
    for (int k = 1; k <= 2; k++)
      if (mq[k].v && mq[k].rw && mq[k].wa == ra) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    ins_t z;
    z = '{ra1: 0, ra2: 0, wa: 0, rw: 0, ld: 0, v: 0};
    mq.delete();
    for (int k = 0; k < 3; k++) mq.push_back(z);
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_fwdA"}, 32'(hif.forwardAE), 0);
    chk({pfx, "_fwdB"}, 32'(hif.forwardBE), 0);
    chk({pfx, "_stl"},  32'({hif.stall_f, hif.stall_d}), 0);
    chk({pfx, "_fls"},  32'({hif.flush_d, hif.flush_e}), 0);
    chk({pfx, "_cnt"},  32'({hif.stall_count, hif.flush_count}), 0);
  endtask

  // Called at a negedge: hold reset through one rising edge with noisy inputs.
  task automatic do_reset();
    rst = 1'b0;
    hif.ra1_d = 4'($urandom); hif.ra2_d = 4'($urandom); hif.wa_d = 4'($urandom);
    hif.reg_write_d = 1'b1; hif.mem_to_reg_d = 1'b1; hif.branch_taken_e = 1'b1;
    #1 chk_all_zero("rst");
    @(posedge clk);
    #1 chk_all_zero("rst_hold");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Apply Decode inputs at negedge and compare combinational outputs before the edge.
  task automatic step(input logic [3:0] a1, a2, w, input bit rw, ld, br);
    bit lu;
    cur = '{ra1: a1, ra2: a2, wa: w, rw: rw, ld: ld, v: 1};
    cur_br = br;
    hif.ra1_d = a1; hif.ra2_d = a2; hif.wa_d = w;
    hif.reg_write_d = rw; hif.mem_to_reg_d = ld; hif.branch_taken_e = br;
    #1;
    lu   = mq[0].v && mq[0].ld && (mq[0].wa == a1 || mq[0].wa == a2);
    x_st = lu && !br;
    x_fe = lu || br;
    chk("fwdA",    32'(hif.forwardAE), 32'(exp_fwd(mq[0].ra1)));
    chk("fwdB",    32'(hif.forwardBE), 32'(exp_fwd(mq[0].ra2)));
    chk("stall_f", 32'(hif.stall_f), 32'(x_st));
    chk("stall_d", 32'(hif.stall_d), 32'(x_st));
    chk("flush_d", 32'(hif.flush_d), 32'(br));
    chk("flush_e", 32'(hif.flush_e), 32'(x_fe));
    chk("stall_count", 32'(hif.stall_count), 32'(m_stall));
    chk("flush_count", 32'(hif.flush_count), 32'(m_flush));
  endtask

  task automatic tick();
    ins_t n;
    @(posedge clk);
    n = cur;
    n.v = !x_fe;
    mq.push_front(n);
    void'(mq.pop_back());
    if (x_st && m_stall < CMAX) m_stall++;
    if (cur_br && m_flush < CMAX) m_flush++;
    @(negedge clk);
  endtask

  initial begin
    n_tot = 0; n_bad = 0;
    rst = 1'b0;
    hif.ra1_d = '0; hif.ra2_d = '0; hif.wa_d = '0;
    hif.reg_write_d = 1'b0; hif.mem_to_reg_d = 1'b0; hif.branch_taken_e = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // ALU chain: M forward for the next instruction, W forward two behind.
    step(0, 0, 3, 1, 0, 0); tick();
    step(3, 0, 7, 0, 0, 0); tick();
    step(0, 3, 8, 0, 0, 0); chk("alu_fwdA_M", 32'(hif.forwardAE), 2); tick();
    step(0, 0, 9, 0, 0, 0); chk("alu_fwdB_W", 32'(hif.forwardBE), 1); tick();

    // Both M and W write r5: M must win.
    do_reset();
    step(0, 0, 5, 1, 0, 0); tick();
    step(0, 0, 5, 1, 0, 0); tick();
    step(5, 0, 6, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0); chk("dbl_fwdA", 32'(hif.forwardAE), 2); tick();

    // Load-use: single-cycle stall, then W forward.
    do_reset();
    step(0, 0, 2, 1, 1, 0); tick();
    step(0, 2, 9, 0, 0, 0);
    chk("lu_stall", 32'({hif.stall_f, hif.stall_d, hif.flush_e, hif.flush_d}), 32'b1110);
    tick();
    step(0, 2, 9, 0, 0, 0);
    chk("lu_release", 32'(hif.stall_d), 0);
    chk("lu_cnt", 32'(hif.stall_count), 1);
    tick();
    step(0, 0, 0, 0, 0, 0); chk("lu_fwdB_W", 32'(hif.forwardBE), 1); tick();

    // Branch coincident with load-use: branch wins.
    do_reset();
    step(0, 0, 2, 1, 1, 0); tick();
    step(2, 0, 0, 0, 0, 1);
    chk("br_ctl", 32'({hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e}), 32'b0011);
    tick();
    step(0, 0, 0, 0, 0, 0);
    chk("br_fcnt", 32'(hif.flush_count), 1);
    chk("br_scnt", 32'(hif.stall_count), 0);
    tick();

    // Saturation: load r4 re-presented so load-use recurs every other cycle (>19 stalls).
    do_reset();
    step(0, 0, 4, 1, 1, 0); tick();
    for (int i = 0; i < 44; i++) begin
      step(4, 0, 4, 1, 1, 0); tick();
    end
    step(0, 0, 0, 0, 0, 0); chk("sat_cnt", 32'(hif.stall_count), CMAX); tick();

    // Asynchronous reset in the middle of a stall.
    do_reset();
    step(0, 0, 2, 1, 1, 0); tick();
    step(2, 0, 0, 0, 0, 0);
    chk("ar_pre", 32'(hif.stall_d), 1);
    rst = 1'b0;
    #1 chk_all_zero("ar_now");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(2, 0, 0, 0, 0, 0); chk("ar_lu_gone", 32'(hif.stall_d), 0); tick();
    step(0, 0, 0, 0, 0, 0); chk("ar_fwdA", 32'(hif.forwardAE), 0); tick();

    // Randomized traffic over a small register set to provoke frequent hits.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
